// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state enum and the per-operation context captured at issue.
package mdu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  // What the in-flight operation will do when it reaches FIX.
  typedef enum logic [1:0] {
    KIND_MUL,
    KIND_DIV,
    KIND_DZERO
  } mdu_kind_e;

  // neg_lo: negate the product (multiply) or the quotient (divide).
  // neg_hi: negate the remainder (divide only).
  typedef struct packed {
    mdu_kind_e kind;
    logic      neg_lo;
    logic      neg_hi;
  } mdu_ctx_t;

  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return op <= MDU_OP_MTLO;
  endfunction

  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction; the extra top bit of diff is the borrow (sign).
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    q_bit    = ~diff[WIDTH+1];
    // The partial remainder is always below the divisor, so it fits WIDTH bits.
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter_hilo.sv
// Iterative multiply/divide unit with integrated HI/LO registers.
// MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider; both
// run on magnitudes and apply the sign in a single FIX cycle that commits
// HI/LO. Optional build macro MDU_FAST_MUL_EN replaces the iterative
// multiply with a single-cycle combinational multiplier.
module mdu_iter_hilo
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  // Multiplicand or divisor magnitude.
  logic [WIDTH-1:0]   opnd_q;
  mdu_ctx_t           ctx_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept;
  logic               cnt_last;
  logic               mul_last;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg  = a_i[WIDTH-1];
  assign b_neg  = b_i[WIDTH-1];
  assign b_zero = (b_i == '0);
  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;

  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MDU_FAST_MUL_EN
  // Whole product in one MUL cycle, registered into acc_q ahead of FIX.
  assign mul_last = 1'b1;
  assign mul_next = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  logic [WIDTH:0] mul_sum;

  // Add the multiplicand when the current multiplier LSB is set, then shift right.
  assign mul_last = cnt_last;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  mdu_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem          (acc_q[2*WIDTH-1:WIDTH]),
    .divisor      (opnd_q),
    .dividend_bit (acc_q[WIDTH-1]),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  assign prod_fix = ctx_q.neg_lo ? -acc_q : acc_q;
  assign quo_fix  = ctx_q.neg_lo ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = ctx_q.neg_hi ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // Next-state, issue decision and status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    accept     = 1'b0;
    busy_o     = 1'b0;
    ready_o    = 1'b0;
    div_zero_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d    = ST_IDLE;
        ready_o    = (state_q == ST_DONE);
        div_zero_o = (state_q == ST_DONE) && (ctx_q.kind == KIND_DZERO);
        // Flush wins over start; invalid ops are dropped.
        if (start_i && !flush_i && op_valid(op_i)) begin
          accept = 1'b1;
          if (op_is_mul(op_i)) begin
            state_d = ST_MUL;
          end else if (op_is_div(op_i)) begin
            state_d = b_zero ? ST_FIX : ST_DIV;
          end
        end
      end
      ST_MUL: begin
        busy_o = 1'b1;
        if (flush_i)       state_d = ST_IDLE;
        else if (mul_last) state_d = ST_FIX;
      end
      ST_DIV: begin
        busy_o = 1'b1;
        if (flush_i)       state_d = ST_IDLE;
        else if (cnt_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy_o  = 1'b1;
        state_d = flush_i ? ST_IDLE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, iteration datapath and HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      ctx_q  <= '{kind: KIND_MUL, neg_lo: 1'b0, neg_hi: 1'b0};
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            cnt_q <= '0;
            case (op_i)
              MDU_OP_MULT: begin
                opnd_q <= a_mag;
                acc_q  <= {{WIDTH{1'b0}}, b_mag};
                ctx_q  <= '{kind: KIND_MUL, neg_lo: a_neg ^ b_neg, neg_hi: 1'b0};
              end
              MDU_OP_MULTU: begin
                opnd_q <= a_i;
                acc_q  <= {{WIDTH{1'b0}}, b_i};
                ctx_q  <= '{kind: KIND_MUL, neg_lo: 1'b0, neg_hi: 1'b0};
              end
              MDU_OP_DIV: begin
                opnd_q <= b_mag;
                acc_q  <= {{WIDTH{1'b0}}, a_mag};
                ctx_q  <= '{kind: b_zero ? KIND_DZERO : KIND_DIV,
                            neg_lo: a_neg ^ b_neg, neg_hi: a_neg};
              end
              MDU_OP_DIVU: begin
                opnd_q <= b_i;
                acc_q  <= {{WIDTH{1'b0}}, a_i};
                ctx_q  <= '{kind: b_zero ? KIND_DZERO : KIND_DIV,
                            neg_lo: 1'b0, neg_hi: 1'b0};
              end
              MDU_OP_MTHI: hi_q <= a_i;
              MDU_OP_MTLO: lo_q <= a_i;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= mul_next;
        end
        ST_DIV: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= {rem_next, acc_q[WIDTH-2:0], q_bit};
        end
        ST_FIX: begin
          if (!flush_i) begin
            case (ctx_q.kind)
              KIND_MUL: {hi_q, lo_q} <= prod_fix;
              KIND_DIV: begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter_hilo.sv
// Self-checking bench for mdu_iter_hilo: directed corner cases plus random
// multiply/divide ops compared against a plain-arithmetic 64-bit model.
module tb_mdu_iter_hilo;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;
  localparam int DZ_LAT  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [2:0]    op_i;
  logic [W-1:0]  a_i, b_i;
  logic          flush_i;
  logic          busy_o, ready_o, div_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_iter_hilo #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .div_zero_o (div_zero_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic straight from the op definitions.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                inout logic [W-1:0] hi, inout logic [W-1:0] lo, output bit dz);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_OP_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      MDU_OP_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      MDU_OP_DIV: begin
        if (b == '0) dz = 1'b1;
        else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
      end
      MDU_OP_DIVU: begin
        if (b == '0) dz = 1'b1;
        else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Caller is between edges; drives one issue cycle, returns just after the accept edge.
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic count_ready(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
  endtask

  // Issue an op, wait (bounded) for ready_o, check latency and results.
  // Returns at the falling edge inside the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit dz;
    int lat, cyc;
    model(op, a, b, m_hi, m_lo, dz);
    lat = dz ? DZ_LAT : (op_is_mul(op) ? MUL_LAT : DIV_LAT);
    launch(op, a, b);
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, ".busy"}, busy_o, 1);
      if (ready_o) begin cyc = c; break; end
    end
    check({tag, ".latency"}, cyc, lat);
    check({tag, ".hi"}, hi_o, m_hi);
    check({tag, ".lo"}, lo_o, m_lo);
    check({tag, ".divzero"}, div_zero_o, dz);
  endtask

  initial begin
    int pulses;
    logic [2:0] rop;
    logic [W-1:0] ra, rb, save_hi, save_lo;

    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", busy_o, 0);
    check("rst.ready", ready_o, 0);
    rst = 1'b0;
    count_ready(50, pulses);
    check("idle.ready_pulses", pulses, 0);
    check("idle.hi", hi_o, 0);
    check("idle.lo", lo_o, 0);
    check("idle.busy", busy_o, 0);

    run_op("mult", MDU_OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult.hi_const", hi_o, 32'hFFFF_FFFF);
    check("mult.lo_const", lo_o, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op("multu", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu.hi_const", hi_o, 32'h0000_0001);
    check("multu.lo_const", lo_o, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op("div", MDU_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div.lo_const", lo_o, 32'hFFFF_FFFD);
    check("div.hi_const", hi_o, 32'hFFFF_FFFF);
    @(negedge clk);
    save_hi = hi_o; save_lo = lo_o;
    run_op("divu0", MDU_OP_DIVU, 32'd7, 32'd0);
    check("divu0.hi_kept", hi_o, save_hi);
    check("divu0.lo_kept", lo_o, save_lo);
    @(negedge clk);
    run_op("ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf.lo_const", lo_o, 32'h8000_0000);
    check("ovf.hi_const", hi_o, 32'h0);

    // Moves to HI/LO: visible the cycle after the accept edge, never busy.
    @(negedge clk);
    launch(MDU_OP_MTHI, 32'h1234_5678, 32'h0);
    check("mthi.hi", hi_o, 32'h1234_5678);
    check("mthi.busy", busy_o, 0);
    @(negedge clk);
    launch(MDU_OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    check("mtlo.lo", lo_o, 32'h9ABC_DEF0);
    check("mtlo.busy", busy_o, 0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    count_ready(3, pulses);
    check("mtx.ready_pulses", pulses, 0);

    // Flush in the middle of a multiply.
    launch(MDU_OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush.busy", busy_o, 0);
    check("flush.hi", hi_o, m_hi);
    check("flush.lo", lo_o, m_lo);
    count_ready(40, pulses);
    check("flush.ready_pulses", pulses, 0);

    // Flush and start together: flush wins.
    start_i = 1'b1; flush_i = 1'b1; op_i = MDU_OP_MTHI; a_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    check("flushstart.hi", hi_o, m_hi);
    check("flushstart.busy", busy_o, 0);

    // Invalid op is ignored.
    @(negedge clk);
    launch(3'd7, 32'h5555_5555, 32'h3);
    check("badop.busy", busy_o, 0);
    count_ready(5, pulses);
    check("badop.ready_pulses", pulses, 0);

    // Start during busy is ignored; original op completes on schedule.
    begin
      bit dz;
      int cyc;
      model(MDU_OP_MULT, 32'hFFFF_FFF0, 32'h0000_1234, m_hi, m_lo, dz);
      launch(MDU_OP_MULT, 32'hFFFF_FFF0, 32'h0000_1234);
      cyc = 0;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (c == 5) begin start_i = 1'b1; op_i = MDU_OP_MTHI; a_i = 32'hCAFE_F00D; end
        else start_i = 1'b0;
        if (ready_o) begin cyc = c; break; end
      end
      start_i = 1'b0;
      check("busystart.latency", cyc, MUL_LAT);
      check("busystart.hi", hi_o, m_hi);
      check("busystart.lo", lo_o, m_lo);
      count_ready(40, pulses);
      check("busystart.ready_pulses", pulses, 0);
    end

    // Back-to-back: MULT issued in the DONE cycle of a DIV.
    run_op("b2b.div", MDU_OP_DIV, 32'h0000_1000, 32'hFFFF_FFFD);
    run_op("b2b.mult", MDU_OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);

    // Random ops against the model.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    // Reset in the middle of a divide clears everything immediately.
    @(negedge clk);
    launch(MDU_OP_DIVU, 32'hFFFF_0000, 32'h0000_0013);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.hi", hi_o, 0);
    check("midrst.lo", lo_o, 0);
    check("midrst.busy", busy_o, 0);
    check("midrst.ready", ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    count_ready(40, pulses);
    check("midrst.ready_pulses", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
